// File: rtl/alu_dec_pkg.sv
// Shared types and encodings for the multi-lane ALU control decode stage.
package alu_dec_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_SLT   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_XOR   = 4'b1010,
    ALU_SLTU  = 4'b1100,
    ALU_EQ    = 4'b1101,
    ALU_SLL   = 4'b1110,
    ALU_COUNT = 4'b1111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    CNT_CLZ  = 2'b00,
    CNT_CTZ  = 2'b01,
    CNT_CPOP = 2'b10
  } cnt_sel_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  // funct7 pattern that selects the count-op group under shift-left-immediate
  localparam logic [6:0] F7_COUNT = 7'b0110000;

endpackage

// File: rtl/alu_dec_lane.sv
// Combinational decode of one raw instruction into ALU control, count select
// and an illegal flag. Illegal encodings always report ALU_ADD / CNT_CLZ.
module alu_dec_lane
  import alu_dec_pkg::*;
(
  input  logic [31:0] instr_i,
  output alu_ctrl_e   ctrl_o,
  output cnt_sel_e    cnt_sel_o,
  output logic        illegal_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       opb5;
  logic       f7b5;
  logic       unused_bits;

  assign opcode      = instr_i[6:0];
  assign funct3      = instr_i[14:12];
  assign opb5        = instr_i[5];
  assign f7b5        = instr_i[30];
  assign unused_bits = ^{instr_i[19:15], instr_i[11:7]};

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    ctrl_o    = ALU_ADD;
    cnt_sel_o = CNT_CLZ;
    illegal_o = 1'b0;
    case (opcode)
      OP_LD, OP_ST, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: ctrl_o = ALU_ADD;
      OP_BR: begin
        case (funct3[2:1])
          2'b00:   ctrl_o = ALU_EQ;
          2'b10:   ctrl_o = ALU_SLT;
          2'b11:   ctrl_o = ALU_SLTU;
          default: illegal_o = 1'b1;
        endcase
      end
      OP_R, OP_IMM: begin
        case (funct3)
          3'b000: ctrl_o = (opb5 && f7b5) ? ALU_SUB : ALU_ADD;
          3'b010: ctrl_o = ALU_SLT;
          3'b011: ctrl_o = ALU_SLTU;
          3'b100: ctrl_o = ALU_XOR;
          3'b110: ctrl_o = ALU_OR;
          3'b111: ctrl_o = ALU_AND;
          3'b101: ctrl_o = f7b5 ? ALU_SRA : ALU_SRL;
          default: begin
            // Count ops live only in the immediate form, with rs2 field 0..2
            if (!f7b5) begin
              ctrl_o = ALU_SLL;
            end else if (!opb5 && instr_i[31:25] == F7_COUNT && instr_i[24:20] <= 5'd2) begin
              ctrl_o    = ALU_COUNT;
              cnt_sel_o = cnt_sel_e'(instr_i[21:20]);
            end else begin
              illegal_o = 1'b1;
            end
          end
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
    if (illegal_o) begin
      ctrl_o    = ALU_ADD;
      cnt_sel_o = CNT_CLZ;
    end
  end

endmodule

// File: rtl/alu_dec_stage.sv
// Registered multi-lane ALU control decoder: per-lane decode, a 2-entry
// valid/ready skid buffer with flush, and a saturating illegal-lane counter.
module alu_dec_stage
  import alu_dec_pkg::*;
#(
  parameter int LANES = 2,
  parameter int TAG_W = 6,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES-1:0]   in_lane_en,
  input  logic [LANES*32-1:0] in_instr,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES-1:0]   out_lane_en,
  output logic [LANES*4-1:0] out_ctrl,
  output logic [LANES*2-1:0] out_cnt_sel,
  output logic [LANES-1:0]   out_illegal,
  output logic [TAG_W-1:0]   out_tag,
  output logic [CNT_W-1:0]   illegal_cnt
);

  localparam int ADD_W = $clog2(LANES + 1);
  localparam int SUM_W = CNT_W + ADD_W;

  typedef struct packed {
    logic [LANES-1:0]   lane_en;
    logic [LANES*4-1:0] ctrl;
    logic [LANES*2-1:0] cnt_sel;
    logic [LANES-1:0]   illegal;
    logic [TAG_W-1:0]   tag;
  } bundle_t;

  logic [LANES*4-1:0] dec_ctrl;
  logic [LANES*2-1:0] dec_cnt_sel;
  logic [LANES-1:0]   dec_ill;
  bundle_t            in_bundle;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    alu_ctrl_e lane_ctrl;
    cnt_sel_e  lane_cnt_sel;
    logic      lane_ill;

    alu_dec_lane u_lane (
      .instr_i   (in_instr[32*i +: 32]),
      .ctrl_o    (lane_ctrl),
      .cnt_sel_o (lane_cnt_sel),
      .illegal_o (lane_ill)
    );

    assign dec_ctrl[4*i +: 4]    = in_lane_en[i] ? lane_ctrl : ALU_ADD;
    assign dec_cnt_sel[2*i +: 2] = in_lane_en[i] ? lane_cnt_sel : CNT_CLZ;
    assign dec_ill[i]            = in_lane_en[i] & lane_ill;
  end

  assign in_bundle = '{lane_en: in_lane_en, ctrl: dec_ctrl, cnt_sel: dec_cnt_sel,
                       illegal: dec_ill, tag: in_tag};

  bundle_t          main_q, main_d, skid_q, skid_d;
  logic             main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADD_W-1:0] ill_add;
  logic [SUM_W-1:0] cnt_sum;
  logic             accept, xfer;

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready & ~flush;
  assign xfer     = main_valid_q & out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || xfer) begin
      // Output slot frees up: the older skid entry always goes first
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) main_d = in_bundle;
      end
    end else if (accept) begin
      skid_d       = in_bundle;
      skid_valid_d = 1'b1;
    end
  end

  always_comb begin
    ill_add = '0;
    for (int i = 0; i < LANES; i++) ill_add = ill_add + ADD_W'(dec_ill[i]);
    cnt_sum = SUM_W'(cnt_q) + SUM_W'(ill_add);
    cnt_d   = cnt_q;
    if (accept) cnt_d = (cnt_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  // NOTE: buffer data registers are reset too, so every output reads 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      // NOTE: state updates are non-blocking so all registers sample pre-edge values.
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid   = main_valid_q;
  assign out_lane_en = main_q.lane_en;
  assign out_ctrl    = main_q.ctrl;
  assign out_cnt_sel = main_q.cnt_sel;
  assign out_illegal = main_q.illegal;
  assign out_tag     = main_q.tag;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_dec_stage.sv
// Self-checking bench for alu_dec_stage: hand-decoded vector table streamed
// through a scoreboard, plus directed stall, flush, saturation and reset cases.
module tb_alu_dec_stage;

  localparam int LANES = 2;
  localparam int TAG_W = 6;
  localparam int CNT_W = 4;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_lane_en, out_lane_en, out_illegal;
  logic [63:0] in_instr;
  logic [5:0]  in_tag, out_tag;
  logic [7:0]  out_ctrl;
  logic [3:0]  out_cnt_sel, illegal_cnt;

  alu_dec_stage #(.LANES(LANES), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_lane_en(in_lane_en),
    .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane_en(out_lane_en),
    .out_ctrl(out_ctrl), .out_cnt_sel(out_cnt_sel), .out_illegal(out_illegal),
    .out_tag(out_tag), .illegal_cnt(illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctrl/cs/ill are {lane1, lane0}
  typedef struct {
    logic [1:0]  en;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [7:0]  ctrl;
    logic [3:0]  cs;
    logic [1:0]  ill;
  } vec_t;

  typedef struct {
    logic [1:0] en;
    logic [7:0] ctrl;
    logic [3:0] cs;
    logic [1:0] ill;
    logic [5:0] tag;
  } exp_t;

  localparam int NV = 15;
  vec_t vecs[NV];
  vec_t bad_vec;
  exp_t sb[$];
  exp_t cur_exp;
  int   total = 0;
  int   bad = 0;
  int   model_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v, input logic [5:0] tag);
    in_valid     = 1'b1;
    in_lane_en   = v.en;
    in_instr     = {v.i1, v.i0};
    in_tag       = tag;
    cur_exp.en   = v.en;
    cur_exp.ctrl = v.ctrl;
    cur_exp.cs   = v.cs;
    cur_exp.ill  = v.ill;
    cur_exp.tag  = tag;
  endtask

  // Present a bundle and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic send(input vec_t v, input logic [5:0] tag, input logic rnd);
    drive(v, tag);
    for (int n = 0; ; n++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_ready) break;
      if (n == 100) begin
        check("accept_timeout", 32'(in_ready), 1);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and counter model, sampled mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        model_cnt = 0;
      end else begin
        check("illegal_cnt", 32'(illegal_cnt), 32'(model_cnt));
        if (out_valid && out_ready && !flush) begin
          check("out_expected", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("out_lane_en", 32'(out_lane_en), 32'(e.en));
            check("out_ctrl", 32'(out_ctrl), 32'(e.ctrl));
            check("out_cnt_sel", 32'(out_cnt_sel), 32'(e.cs));
            check("out_illegal", 32'(out_illegal), 32'(e.ill));
            check("out_tag", 32'(out_tag), 32'(e.tag));
          end
        end
        if (flush) begin
          sb.delete();
        end else if (in_valid && in_ready) begin
          sb.push_back(cur_exp);
          model_cnt = model_cnt + int'(cur_exp.ill[0]) + int'(cur_exp.ill[1]);
          if (model_cnt > 15) model_cnt = 15;
        end
      end
    end
  end

  initial begin
    vecs[0]  = '{2'b11, 32'h40B50533, 32'h00B50533, 8'h01, 4'b0000, 2'b00}; // sub | add
    vecs[1]  = '{2'b11, 32'h60051513, 32'h60251513, 8'hFF, 4'b1000, 2'b00}; // clz | cpop
    vecs[2]  = '{2'b11, 32'h60051533, 32'h60151513, 8'hF0, 4'b0100, 2'b01}; // R count (ill) | ctz
    vecs[3]  = '{2'b11, 32'h00B50063, 32'h00B56063, 8'hCD, 4'b0000, 2'b00}; // beq | bltu
    vecs[4]  = '{2'b11, 32'h00B52063, 32'h00B55063, 8'h50, 4'b0000, 2'b01}; // br f3=010 (ill) | bge
    vecs[5]  = '{2'b11, 32'h40155513, 32'h00155513, 8'h67, 4'b0000, 2'b00}; // srai | srli
    vecs[6]  = '{2'b11, 32'h00B54533, 32'h00B56533, 8'h3A, 4'b0000, 2'b00}; // xor | or
    vecs[7]  = '{2'b11, 32'h00B57533, 32'h00152513, 8'h52, 4'b0000, 2'b00}; // and | slti
    vecs[8]  = '{2'b11, 32'h00B53533, 32'h00151513, 8'hEC, 4'b0000, 2'b00}; // sltu | slli
    vecs[9]  = '{2'b11, 32'hC0050513, 32'h00052503, 8'h00, 4'b0000, 2'b00}; // addi neg imm | lw
    vecs[10] = '{2'b11, 32'h12345537, 32'h0000006F, 8'h00, 4'b0000, 2'b00}; // lui | jal
    vecs[11] = '{2'b11, 32'h60351513, 32'h40151513, 8'h00, 4'b0000, 2'b11}; // rs2=3 | bad f7
    vecs[12] = '{2'b01, 32'h0000007F, 32'h0000007F, 8'h00, 4'b0000, 2'b01}; // lane1 disabled
    vecs[13] = '{2'b10, 32'h40B50533, 32'h60051513, 8'hF0, 4'b0000, 2'b00}; // lane0 disabled
    vecs[14] = '{2'b00, 32'h0000007F, 32'h60251513, 8'h00, 4'b0000, 2'b00}; // both disabled
    bad_vec  = '{2'b11, 32'h0000007F, 32'h0000007F, 8'h00, 4'b0000, 2'b11};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_lane_en = '0; in_instr = '0; in_tag = '0;
    cur_exp = '{2'b00, 8'h00, 4'h0, 2'b00, 6'h00};

    #2;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_illegal_cnt", 32'(illegal_cnt), 0);
    check("rst_out_ctrl", 32'(out_ctrl), 0);
    check("rst_out_tag", 32'(out_tag), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // One-cycle latency from acceptance
    out_ready = 1'b1;
    send(vecs[0], 6'd1, 1'b0);
    check("lat_out_valid", 32'(out_valid), 1);
    check("lat_out_ctrl", 32'(out_ctrl), 32'h01);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Back-to-back table stream, then again under random backpressure
    for (int i = 0; i < NV; i++) send(vecs[i], 6'(i), 1'b0);
    for (int i = 0; i < NV; i++) send(vecs[i], 6'(40 + i), 1'b1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Stall: tag1 held, tag2 in skid, tag3 waits; release gives 1,2,3 back to back
    out_ready = 1'b0;
    send(vecs[5], 6'd1, 1'b0);
    send(vecs[6], 6'd2, 1'b0);
    drive(vecs[7], 6'd3);
    @(posedge clk); #1;
    check("stall_out_valid", 32'(out_valid), 1);
    check("stall_out_tag", 32'(out_tag), 1);
    check("stall_in_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    @(negedge clk);
    check("rel_tag1", 32'(out_tag), 1);
    @(negedge clk);
    check("rel_tag2", 32'(out_tag), 2);
    check("rel_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rel_tag3", 32'(out_tag), 3);
    check("rel_valid3", 32'(out_valid), 1);
    @(posedge clk); #1;

    // Flush with skid full, then flush with only the output entry full
    out_ready = 1'b0;
    send(vecs[0], 6'd10, 1'b0);
    send(vecs[1], 6'd11, 1'b0);
    check("full_in_ready", 32'(in_ready), 0);
    drive(vecs[2], 6'd12);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush1_out_valid", 32'(out_valid), 0);
    check("flush1_in_ready", 32'(in_ready), 1);
    send(vecs[3], 6'd13, 1'b0);
    drive(vecs[4], 6'd14);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush2_out_valid", 32'(out_valid), 0);
    check("flush2_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_flush_idle", 32'(out_valid), 0);
    end
    @(posedge clk); #1;

    // Counter saturation, then a fully disabled illegal bundle
    for (int k = 0; k < 10; k++) send(bad_vec, 6'(30 + k), 1'b0);
    send(vecs[14], 6'd50, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("cnt_saturated", 32'(illegal_cnt), 15);

    for (int n = 0; n < 50 && sb.size() != 0; n++) @(posedge clk);
    #1;
    check("drain_empty", 32'(sb.size()), 0);

    // Asynchronous reset while stalled with both entries full
    out_ready = 1'b0;
    send(vecs[0], 6'd20, 1'b0);
    send(vecs[1], 6'd21, 1'b0);
    in_valid = 1'b0;
    check("pre_rst_out_valid", 32'(out_valid), 1);
    check("pre_rst_in_ready", 32'(in_ready), 0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_in_ready", 32'(in_ready), 1);
    check("arst_illegal_cnt", 32'(illegal_cnt), 0);
    check("arst_out_tag", 32'(out_tag), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
